fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 86 ++++++++
 tb/tb_fetch_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one-cycle-latency fetches under a credit limit,
// buffers {pc,inst} pairs for decode, and flushes on redirect or reset.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            inflight_q;
  logic [31:0]     inflight_pc;
  logic [31:0]     fetch_pc;
  logic [CW:0]     credit_used;
  logic            accept, push, pop;

  // An in-flight fetch already owns a slot, so it counts against the queue.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign imem_req    = !rst && !redirect_valid && (credit_used < DEPTH_C);
  assign imem_addr   = fetch_pc;
  assign accept      = imem_req && imem_ready;
  assign push        = imem_rvalid && inflight_q && !redirect_valid && !rst;
  assign pop         = out_valid && out_ready && !redirect_valid;

  assign out_valid   = (count != '0);
  assign out_pc      = out_valid ? mem[rd_ptr].pc   : 32'h0;
  assign out_inst    = out_valid ? mem[rd_ptr].inst : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= PC_RESET;
      inflight_q  <= 1'b0;
      inflight_pc <= PC_RESET;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      inflight_q  <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: inflight_pc, inst: imem_rdata};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a one-cycle-latency instruction memory responder.
module tb_fetch_queue;
  localparam logic [31:0] K = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
  logic        out_ready;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_pc;

  fetch_queue #(.DEPTH(4), .PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Memory answers every accepted request exactly one cycle later.
  always @(posedge clk) begin
    imem_rvalid <= imem_req && imem_ready;
    imem_rdata  <= imem_addr ^ K;
  end

  task test_reset;
    rst = 1'b1; out_ready = 1'b1; imem_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h want=0", out_pc); end
    checks++; if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h want=0", out_inst); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
  endtask

  task test_startup;
    rst = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL start_req got=%b/%h want=1/0", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL start_c1_valid got=%b want=0", out_valid); end
    @(negedge clk);
    exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== (exp_pc ^ K)) begin
        failures++; $display("FAIL stream[%0d] got=%b/%h/%h want=1/%h/%h", i, out_valid, out_pc, out_inst, exp_pc, exp_pc ^ K);
      end
      exp_pc += 32'd4;
      @(negedge clk);
    end
  endtask

  task test_backpressure;
    int pops;
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req got=%b want=0", imem_req); end
    checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin failures++; $display("FAIL bp_head got=%b/%h want=1/%h", out_valid, out_pc, exp_pc); end
    out_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 30 && pops < 12; c++) begin
      if (out_valid) begin
        checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL bp_seq got=%h want=%h", out_pc, exp_pc); end
        exp_pc += 32'd4; pops++;
      end
      @(negedge clk);
    end
    checks++; if (pops !== 12) begin failures++; $display("FAIL bp_timeout got=%0d want=12", pops); end
  endtask

  task test_redirect_full;
    bit found;
    out_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (imem_rvalid && !imem_req) found = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!found) begin failures++; $display("FAIL rd_full_timeout got=0 want=1"); end
    redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rd_req_n got=%b want=0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0; out_ready = 1'b1; #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_n1_valid got=%b want=0", out_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL rd_n1_req got=%b/%h want=1/100", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_n2_valid got=%b want=0", out_valid); end
    @(negedge clk);
    exp_pc = 32'h100;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== (exp_pc ^ K)) begin
        failures++; $display("FAIL rd_seq[%0d] got=%b/%h/%h want=1/%h/%h", i, out_valid, out_pc, out_inst, exp_pc, exp_pc ^ K);
      end
      exp_pc += 32'd4;
      @(negedge clk);
    end
  endtask

  task test_imem_stall;
    int pops;
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    @(negedge clk);
    redirect_valid = 1'b0; imem_ready = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || out_valid !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d] got=%b/%h/%b want=1/10/0", k, imem_req, imem_addr, out_valid);
      end
      @(negedge clk);
    end
    imem_ready = 1'b1;
    exp_pc = 32'h10; pops = 0;
    for (int c = 0; c < 20 && pops < 6; c++) begin
      if (out_valid) begin
        checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL stall_seq got=%h want=%h", out_pc, exp_pc); end
        exp_pc += 32'd4; pops++;
      end
      @(negedge clk);
    end
    checks++; if (pops !== 6) begin failures++; $display("FAIL stall_timeout got=%0d want=6", pops); end
  endtask

  task test_redirect_align;
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0; #1;
    checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL align_addr got=%h want=200", imem_addr); end
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin failures++; $display("FAIL align_out got=%b/%h want=1/200", out_valid, out_pc); end
  endtask

  task test_reset_mid;
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mrst_req got=%b want=0", imem_req); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL mrst_state got=%b/%h/%h want=0/0/0", out_valid, out_pc, imem_addr);
    end
    rst = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL mrst_req1 got=%b/%h want=1/0", imem_req, imem_addr); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_c1 got=%b want=0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL mrst_c2 got=%b/%h want=1/0", out_valid, out_pc); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4) begin failures++; $display("FAIL mrst_c3 got=%b/%h want=1/4", out_valid, out_pc); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_backpressure();
    test_redirect_full();
    test_imem_stall();
    test_redirect_align();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
